// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle between the two caches and the memory arbiter.
//   Petition side (instruction/data cache): petFromIcache, addrFromIcache,
//     petFromDcache, addrFromDcache, dcacheIsWrite, dataFromDcache.
//   Completion side: icacheServiceReady, dcacheServiceReady,
//     grantIcache, grantDcache.
//   Memory side: memAddr, memRead, memWrite, memWriteData.
// Modports: master = cache side (drives petitions), slave = arbiter.
interface mem_arbiter_if #(
  parameter int addr_width       = 16,
  parameter int cache_line_width = 256
);
  logic                        petFromIcache;
  logic [addr_width-1:0]       addrFromIcache;
  logic                        petFromDcache;
  logic [addr_width-1:0]       addrFromDcache;
  logic                        dcacheIsWrite;
  logic [cache_line_width-1:0] dataFromDcache;
  logic                        icacheServiceReady;
  logic                        dcacheServiceReady;
  logic                        grantIcache;
  logic                        grantDcache;
  logic [addr_width-1:0]       memAddr;
  logic                        memRead;
  logic                        memWrite;
  logic [cache_line_width-1:0] memWriteData;

  modport master (
    output petFromIcache, addrFromIcache, petFromDcache, addrFromDcache,
           dcacheIsWrite, dataFromDcache,
    input  icacheServiceReady, dcacheServiceReady, grantIcache, grantDcache,
           memAddr, memRead, memWrite, memWriteData
  );

  modport slave (
    input  petFromIcache, addrFromIcache, petFromDcache, addrFromDcache,
           dcacheIsWrite, dataFromDcache,
    output icacheServiceReady, dcacheServiceReady, grantIcache, grantDcache,
           memAddr, memRead, memWrite, memWriteData
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the instruction
// cache and the data cache. Round-robin grant, fixed latency modelled with a
// down-counter, one-cycle ServiceReady pulse to the owner at the end.
// Ports:
//   clk    - clock, all state on rising edge
//   reset  - synchronous, active-high
//   bus    - mem_arbiter_if.slave (petitions in, grants/readies/memory out)
module mem_arbiter #(
  parameter int addr_width       = 16,
  parameter int cache_line_width = 256,
  parameter int mem_latency      = 5   // BUSY cycles per service, 1..255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, READY} stateType;
  typedef enum logic {OWNER_I, OWNER_D} ownerType;

  stateType                    state, stateNext;
  ownerType                    owner, lastOwner, winner;
  logic [addr_width-1:0]       lineAddr;
  logic                        writeFlag;
  logic [cache_line_width-1:0] writeLine;
  logic [7:0]                  count;
  logic                        anyPet;
  logic                        active;

  // Next-state and winner selection.
  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    anyPet    = bus.petFromIcache | bus.petFromDcache;
    stateNext = state;
    winner    = OWNER_I;
    if (bus.petFromIcache && bus.petFromDcache)
      winner = (lastOwner == OWNER_I) ? OWNER_D : OWNER_I;  // contention: not the last one served
    else if (bus.petFromDcache)
      winner = OWNER_D;

    case (state)
      IDLE:    if (anyPet) stateNext = BUSY;
      BUSY:    if (count == 8'd0) stateNext = READY;
      READY:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State and service registers.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWNER_I;
      lastOwner <= OWNER_D;
      count     <= 8'd0;
      lineAddr  <= '0;
      writeFlag <= 1'b0;
      // NOTE: the wide line register is reset as well; it is small enough and
      // keeps X out of memWriteData even if the output gating ever changes.
      writeLine <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (anyPet) begin
            owner     <= winner;
            lineAddr  <= (winner == OWNER_D) ? {bus.addrFromDcache[addr_width-1:4], 4'b0}
                                             : {bus.addrFromIcache[addr_width-1:4], 4'b0};
            writeFlag <= bus.dcacheIsWrite && (winner == OWNER_D);
            writeLine <= bus.dataFromDcache;
            count     <= 8'(mem_latency - 1);
          end
        end
        BUSY:    if (count != 8'd0) count <= count - 8'd1;
        READY:   lastOwner <= owner;
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only; all zero in IDLE.
  assign active                 = (state != IDLE);
  assign bus.grantIcache        = active && (owner == OWNER_I);
  assign bus.grantDcache        = active && (owner == OWNER_D);
  assign bus.icacheServiceReady = (state == READY) && (owner == OWNER_I);
  assign bus.dcacheServiceReady = (state == READY) && (owner == OWNER_D);
  assign bus.memRead            = active && !writeFlag;
  assign bus.memWrite           = (state == READY) && writeFlag;
  assign bus.memAddr            = active ? lineAddr : '0;
  assign bus.memWriteData       = active ? writeLine : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations plus a long
// randomized run, all compared every cycle against a transaction-level model
// (a service is a window of cycles [grant+1 .. grant+mem_latency+1]).
module tb_mem_arbiter;
  localparam int AW  = 16;
  localparam int LW  = 256;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if #(.addr_width(AW), .cache_line_width(LW)) bus ();

  mem_arbiter #(.addr_width(AW), .cache_line_width(LW), .mem_latency(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkVec(input string name, input logic [LW-1:0] actual,
                          input logic [LW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model: one service window at a time ----------
  bit            armed = 0;
  int            cyc = 0;
  bit            mActive = 0;
  int            mEnd = 0;
  bit            mOwnerD = 0;
  bit            mLastD = 1;
  logic [AW-1:0] mAddr = '0;
  bit            mWrite = 0;
  logic [LW-1:0] mData = '0;
  bit            mReady;

  always @(negedge clk) begin
    if (armed) begin
      mReady = mActive && (cyc == mEnd);
      checkBit("grantIcache", bus.grantIcache, mActive && !mOwnerD);
      checkBit("grantDcache", bus.grantDcache, mActive && mOwnerD);
      checkBit("icacheServiceReady", bus.icacheServiceReady, mReady && !mOwnerD);
      checkBit("dcacheServiceReady", bus.dcacheServiceReady, mReady && mOwnerD);
      checkBit("memRead", bus.memRead, mActive && !mWrite);
      checkBit("memWrite", bus.memWrite, mReady && mWrite);
      checkVec("memAddr", LW'(bus.memAddr), LW'(mActive ? mAddr : '0));
      checkVec("memWriteData", bus.memWriteData, mActive ? mData : '0);
      checkBit("grantMutex", bus.grantIcache & bus.grantDcache, 1'b0);
    end
    // Advance the model with the inputs the next rising edge will sample.
    if (reset === 1'b1) begin
      armed   = 1;
      mActive = 0;
      mLastD  = 1;
    end else if (armed) begin
      if (mActive) begin
        if (cyc == mEnd) begin
          mActive = 0;
          mLastD  = mOwnerD;
        end
      end else if (bus.petFromIcache || bus.petFromDcache) begin
        mOwnerD = bus.petFromDcache && (!bus.petFromIcache || !mLastD);
        mAddr   = (mOwnerD ? bus.addrFromDcache : bus.addrFromIcache) & ~AW'(16'hF);
        mWrite  = mOwnerD && bus.dcacheIsWrite;
        mData   = bus.dataFromDcache;
        mActive = 1;
        mEnd    = cyc + LAT + 1;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic goCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.petFromIcache  = 1'b0;
    bus.addrFromIcache = '0;
    bus.petFromDcache  = 1'b0;
    bus.addrFromDcache = '0;
    bus.dcacheIsWrite  = 1'b0;
    bus.dataFromDcache = '0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    goCycle();
    goCycle();
    reset = 1'b0;
  endtask

  logic [LW-1:0] pattern;

  initial begin
    reset = 1'b1;
    clearInputs();

    // Reset state.
    doReset();
    @(negedge clk);
    checkBit("rst grantIcache", bus.grantIcache, 1'b0);
    checkBit("rst grantDcache", bus.grantDcache, 1'b0);
    checkBit("rst memRead", bus.memRead, 1'b0);
    checkVec("rst memAddr", LW'(bus.memAddr), '0);

    // Single instruction-cache miss: petition from cycle 0, dropped in cycle 7.
    goCycle();
    bus.petFromIcache  = 1'b1;
    bus.addrFromIcache = 16'h1234;
    for (int k = 0; k < 9; k++) begin
      if (k == 7) bus.petFromIcache = 1'b0;
      @(negedge clk);
      checkBit("t1 grantIcache", bus.grantIcache, k >= 1 && k <= 6);
      checkBit("t1 memRead", bus.memRead, k >= 1 && k <= 6);
      checkBit("t1 icacheServiceReady", bus.icacheServiceReady, k == 6);
      checkVec("t1 memAddr", LW'(bus.memAddr), (k >= 1 && k <= 6) ? LW'(16'h1230) : '0);
      goCycle();
    end

    // Both petitions continuously: I, D, I, D with one IDLE cycle between.
    doReset();
    goCycle();
    bus.petFromIcache  = 1'b1;
    bus.addrFromIcache = 16'h0A05;
    bus.petFromDcache  = 1'b1;
    bus.addrFromDcache = 16'hBEEF;
    for (int k = 0; k < 30; k++) begin
      if (k == 28) begin
        bus.petFromIcache = 1'b0;
        bus.petFromDcache = 1'b0;
      end
      @(negedge clk);
      checkBit("rr grantIcache", bus.grantIcache, (k >= 1 && k <= 6) || (k >= 15 && k <= 20));
      checkBit("rr grantDcache", bus.grantDcache, (k >= 8 && k <= 13) || (k >= 22 && k <= 27));
      checkBit("rr icacheServiceReady", bus.icacheServiceReady, k == 6 || k == 20);
      checkBit("rr dcacheServiceReady", bus.dcacheServiceReady, k == 13 || k == 27);
      if (k >= 8 && k <= 13)
        checkVec("rr memAddr D", LW'(bus.memAddr), LW'(16'hBEE0));
      goCycle();
    end

    // Data-cache write-back; address and data change mid-service.
    doReset();
    goCycle();
    pattern = {8{32'hA5C3_0F1E}};
    bus.petFromDcache  = 1'b1;
    bus.dcacheIsWrite  = 1'b1;
    bus.addrFromDcache = 16'h4567;
    bus.dataFromDcache = pattern;
    for (int k = 0; k < 9; k++) begin
      if (k == 2) begin
        bus.dataFromDcache = ~pattern;
        bus.addrFromDcache = 16'h9999;
      end
      if (k == 7) bus.petFromDcache = 1'b0;
      @(negedge clk);
      checkBit("wb memRead", bus.memRead, 1'b0);
      checkBit("wb memWrite", bus.memWrite, k == 6);
      checkBit("wb dcacheServiceReady", bus.dcacheServiceReady, k == 6);
      checkVec("wb memWriteData", bus.memWriteData, (k >= 1 && k <= 6) ? pattern : '0);
      checkVec("wb memAddr", LW'(bus.memAddr), (k >= 1 && k <= 6) ? LW'(16'h4560) : '0);
      goCycle();
    end

    // Reset during BUSY of a write-back, then a fresh instruction miss.
    doReset();
    goCycle();
    bus.petFromDcache  = 1'b1;
    bus.dcacheIsWrite  = 1'b1;
    bus.dataFromDcache = {8{32'h1357_9BDF}};
    for (int k = 0; k < 14; k++) begin
      if (k == 3) begin
        reset = 1'b1;
        bus.petFromDcache = 1'b0;
        bus.dcacheIsWrite = 1'b0;
      end
      if (k == 4) reset = 1'b0;
      if (k == 5) begin
        bus.petFromIcache  = 1'b1;
        bus.addrFromIcache = 16'h7771;
      end
      if (k == 12) bus.petFromIcache = 1'b0;
      @(negedge clk);
      checkBit("mr grantDcache", bus.grantDcache, k >= 1 && k <= 3);
      checkBit("mr dcacheServiceReady", bus.dcacheServiceReady, 1'b0);
      checkBit("mr memWrite", bus.memWrite, 1'b0);
      checkBit("mr grantIcache", bus.grantIcache, k >= 6 && k <= 11);
      checkBit("mr icacheServiceReady", bus.icacheServiceReady, k == 11);
      goCycle();
    end

    // Petition withdrawn in cycle 2: service still completes, no regrant.
    doReset();
    goCycle();
    bus.petFromIcache  = 1'b1;
    bus.addrFromIcache = 16'h00F8;
    for (int k = 0; k < 11; k++) begin
      if (k == 2) bus.petFromIcache = 1'b0;
      @(negedge clk);
      checkBit("wd grantIcache", bus.grantIcache, k >= 1 && k <= 6);
      checkBit("wd icacheServiceReady", bus.icacheServiceReady, k == 6);
      goCycle();
    end

    // Randomized traffic with occasional resets, model-checked every cycle.
    for (int n = 0; n < 3000; n++) begin
      reset              = ($urandom_range(0, 79) == 0);
      bus.petFromIcache  = ($urandom_range(0, 9) < 5);
      bus.petFromDcache  = ($urandom_range(0, 9) < 5);
      bus.addrFromIcache = AW'($urandom);
      bus.addrFromDcache = AW'($urandom);
      bus.dcacheIsWrite  = $urandom_range(0, 1) == 1;
      for (int w = 0; w < LW / 32; w++)
        bus.dataFromDcache[w*32 +: 32] = $urandom;
      goCycle();
    end

    reset = 1'b0;
    clearInputs();
    repeat (10) goCycle();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
